// File: rtl/adder_serial4.sv
// adder_serial4: nibble-serial two's-complement adder/subtractor with valid/ready handshake
module adder_serial4 #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_a2,
  input  logic             i_sign,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_b,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_busy
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_bop, r_b;
  logic [WIDTH-DIGIT-1:0] r_acc;
  logic [KW-1:0] r_k;
  logic r_c, r_cout, r_ovf;
  logic [DIGIT:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic w_accept, w_last, w_cmsb;
  assign w_accept = r_state == S_IDLE && i_in_valid;
  assign w_last = r_state == S_CALC && r_k == KW'(NDIG - 1);
  assign w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_bop[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
  assign w_res = {w_sum[DIGIT-1:0], r_acc};
  assign w_cmsb = r_a[DIGIT-1] ^ r_bop[DIGIT-1] ^ w_sum[DIGIT-1];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // next-state decode
  always_comb
    w_next = r_state == S_IDLE ? (i_in_valid ? S_CALC : S_IDLE) :
             r_state == S_CALC ? (w_last ? S_DONE : S_CALC) :
             (i_out_ready ? S_IDLE : S_DONE);
  // handshake outputs straight from the state register
  always_comb begin
    o_in_ready = r_state == S_IDLE;
    o_out_valid = r_state == S_DONE;
    o_busy = r_state != S_IDLE;
  end
  // operand capture and one digit per cycle, LSB digit first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a <= '0;
      r_bop <= '0;
      r_acc <= '0;
      r_c <= 1'b0;
      r_k <= '0;
    end else if (w_accept) begin
      r_a <= i_a1;
      r_bop <= i_sign ? ~i_a2 : i_a2;
      r_c <= i_sign;
      r_k <= '0;
    end else if (r_state == S_CALC) begin
      r_a <= r_a >> DIGIT;
      r_bop <= r_bop >> DIGIT;
      r_acc <= w_res[WIDTH-1:DIGIT];
      r_c <= w_sum[DIGIT];
      r_k <= r_k + KW'(1);
    end
  // visible results update only on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_b <= '0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_b <= w_res;
      r_cout <= w_sum[DIGIT];
      r_ovf <= w_cmsb ^ w_sum[DIGIT];
    end
  assign o_b = r_b;
  assign o_cout = r_cout;
  assign o_ovf = r_ovf;
endmodule

// File: tb/tb_adder_serial4.sv
// tb_adder_serial4: randomized and directed checks of adder_serial4 against an arithmetic model
module tb_adder_serial4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, sign = 0;
  logic in_ready, out_valid, cout, ovf, busy;
  logic [15:0] a1 = 0, a2 = 0, b;
  logic [15:0] exp_b = 0;
  logic exp_cout = 0, exp_ovf = 0;
  int n_chk = 0, n_pass = 0;
  adder_serial4 dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a1(a1), .i_a2(a2), .i_sign(sign), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_b(b), .o_cout(cout), .o_ovf(ovf), .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask
  function automatic void model(input logic [15:0] x, y, input logic s);
    logic [16:0] sum;
    logic [15:0] yy;
    yy = s ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + 17'(s);
    exp_b = sum[15:0];
    exp_cout = sum[16];
    exp_ovf = s ? (x[15] != y[15] && sum[15] != x[15]) : (x[15] == y[15] && sum[15] != x[15]);
  endfunction
  task automatic run_op(input logic [15:0] x, y, input logic s);
    int lat;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    a1 = x; a2 = y; sign = s; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    a1 = 16'($urandom); a2 = 16'($urandom); sign = 1'($urandom);
    chk("busy_calc", busy, 1);
    chk("b_held_calc", b, exp_b);
    model(x, y, s);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4);
    chk("b", b, exp_b);
    chk("cout", cout, exp_cout);
    chk("ovf", ovf, exp_ovf);
    chk("busy_done", busy, 1);
    chk("ready_done", in_ready, 0);
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask
  initial begin
    #3;
    chk("rst_b", b, 0); chk("rst_cout", cout, 0); chk("rst_ovf", ovf, 0);
    chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_ready", in_ready, 1);
    #20 rst_n = 1;
    run_op(16'h1234, 16'h0FFF, 0);
    chk("add_b", exp_b, 16'h2233);
    run_op(16'h0005, 16'h0007, 1);
    chk("sub_neg_b", b, 16'hFFFE);
    run_op(16'h0007, 16'h0005, 1);
    chk("sub_pos_c", cout, 1);
    run_op(16'h7FFF, 16'h0001, 0);
    chk("ovf_pos", ovf, 1);
    run_op(16'hFFFF, 16'h0001, 0);
    chk("wrap_c", cout, 1);
    run_op(16'h8000, 16'h0001, 1);
    chk("ovf_neg", ovf, 1);
    for (int i = 0; i < 25; i++) run_op(16'($urandom), 16'($urandom), 1'($urandom));
    // backpressure: hold result while inputs churn
    @(negedge clk);
    a1 = 16'h4321; a2 = 16'h1111; sign = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    model(16'h4321, 16'h1111, 1);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a1 = 16'($urandom); a2 = 16'($urandom); in_valid = 1'(i & 1);
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_b", b, exp_b);
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp_release", in_ready, 1);
    run_op(16'h0101, 16'h0202, 0);
    // reset in the middle of an operation
    @(negedge clk);
    a1 = 16'h1111; a2 = 16'h2222; sign = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_b", b, 0); chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_ready", in_ready, 1);
    exp_b = 0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("mid_rst_novalid", out_valid, 0);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post_rst_novalid", out_valid, 0);
    end
    run_op(16'h00FF, 16'h0001, 0);
    chk("post_rst_b", b, 16'h0100);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
